// File: rtl/mips_data_mem_arbiter.sv
// Two-master (CPU / DMA) arbiter in front of the single-port MIPS data memory.
// Round-robin ownership with bounded bursts; read responses are tagged back to their issuer.
module mips_data_mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  output logic        cpu_readvalid,
  input  logic        dma_read,
  input  logic        dma_write,
  input  logic [31:0] dma_address,
  input  logic [31:0] dma_writedata,
  output logic        dma_waitrequest,
  output logic [31:0] dma_readdata,
  output logic        dma_readvalid,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_readdata,
  output logic        grant_dma
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e          owner_r, owner_next_s;
  owner_e          rr_last_r, rr_last_next_s;
  owner_e          grant_s, other_s;
  logic [BW-1:0]   beats_r, beats_next_s;
  logic            pend_valid_r, pend_valid_next_s;
  logic            pend_who_r, pend_who_next_s;   // 1 = DMA issued the pending read
  logic            cpu_req_s, dma_req_s;
  logic            owner_req_s, other_req_s;
  logic            issue_en_s, issue_rd_s;

  assign cpu_req_s  = cpu_read | cpu_write;
  assign dma_req_s  = dma_read | dma_write;
  // Nothing reaches the memory while frozen or held in reset.
  assign issue_en_s = clk_enable & reset;

  // State register: ownership, burst count, round-robin pointer and response tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r      <= OWN_NONE;
      rr_last_r    <= OWN_DMA;
      beats_r      <= {BW{1'b0}};
      pend_valid_r <= 1'b0;
      pend_who_r   <= 1'b0;
    end else begin
      owner_r      <= owner_next_s;
      rr_last_r    <= rr_last_next_s;
      beats_r      <= beats_next_s;
      pend_valid_r <= pend_valid_next_s;
      pend_who_r   <= pend_who_next_s;
    end
  end

  // Grant selection for the current cycle.
  always_comb begin
    grant_s     = OWN_NONE;
    owner_req_s = 1'b0;
    other_req_s = 1'b0;
    other_s     = OWN_NONE;
    case (owner_r)
      OWN_CPU: begin
        owner_req_s = cpu_req_s;
        other_req_s = dma_req_s;
        other_s     = OWN_DMA;
      end
      OWN_DMA: begin
        owner_req_s = dma_req_s;
        other_req_s = cpu_req_s;
        other_s     = OWN_CPU;
      end
      default: begin
        owner_req_s = 1'b0;
        other_req_s = 1'b0;
        other_s     = OWN_NONE;
      end
    endcase

    if (owner_r == OWN_NONE) begin
      if (cpu_req_s && dma_req_s) begin
        grant_s = (rr_last_r == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (cpu_req_s) begin
        grant_s = OWN_CPU;
      end else if (dma_req_s) begin
        grant_s = OWN_DMA;
      end else begin
        grant_s = OWN_NONE;
      end
    end else if (owner_req_s && ((beats_r < BURST_MAX) || !other_req_s)) begin
      grant_s = owner_r;
    end else if (other_req_s) begin
      grant_s = other_s;
    end else begin
      // An illegal owner encoding also lands here and falls back to NONE.
      grant_s = OWN_NONE;
    end
  end

  // Read-with-write is issued as a write only, so only a pure read is tagged.
  always_comb begin
    case (grant_s)
      OWN_CPU: issue_rd_s = cpu_read & ~cpu_write;
      OWN_DMA: issue_rd_s = dma_read & ~dma_write;
      default: issue_rd_s = 1'b0;
    endcase
  end

  // Next-state logic, applied only on enabled edges.
  always_comb begin
    owner_next_s      = owner_r;
    rr_last_next_s    = rr_last_r;
    beats_next_s      = beats_r;
    pend_valid_next_s = pend_valid_r;
    pend_who_next_s   = pend_who_r;
    if (clk_enable) begin
      if (grant_s == OWN_NONE) begin
        owner_next_s = OWN_NONE;
        beats_next_s = {BW{1'b0}};
      end else if (grant_s == owner_r) begin
        beats_next_s = (beats_r < BURST_MAX) ? (beats_r + BW'(1)) : BURST_MAX;
      end else begin
        owner_next_s   = grant_s;
        rr_last_next_s = grant_s;
        beats_next_s   = BW'(1);
      end
      pend_valid_next_s = issue_rd_s;
      pend_who_next_s   = (grant_s == OWN_DMA);
    end else begin
      pend_valid_next_s = pend_valid_r;
      pend_who_next_s   = pend_who_r;
    end
  end

  // Output logic: memory port mux, wait-requests and response routing.
  always_comb begin
    mem_address   = 32'd0;
    mem_writedata = 32'd0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    if (issue_en_s) begin
      case (grant_s)
        OWN_CPU: begin
          mem_address   = cpu_address;
          mem_writedata = cpu_writedata;
          mem_write     = cpu_write;
          mem_read      = cpu_read & ~cpu_write;
        end
        OWN_DMA: begin
          mem_address   = dma_address;
          mem_writedata = dma_writedata;
          mem_write     = dma_write;
          mem_read      = dma_read & ~dma_write;
        end
        default: begin
          mem_address   = 32'd0;
          mem_writedata = 32'd0;
          mem_write     = 1'b0;
          mem_read      = 1'b0;
        end
      endcase
    end else begin
      mem_address   = 32'd0;
      mem_writedata = 32'd0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
    end

    cpu_waitrequest = cpu_req_s & ~(issue_en_s & (grant_s == OWN_CPU));
    dma_waitrequest = dma_req_s & ~(issue_en_s & (grant_s == OWN_DMA));

    cpu_readvalid = pend_valid_r & ~pend_who_r;
    dma_readvalid = pend_valid_r & pend_who_r;
    cpu_readdata  = cpu_readvalid ? mem_readdata : 32'd0;
    dma_readdata  = dma_readvalid ? mem_readdata : 32'd0;

    grant_dma = (owner_r == OWN_DMA);
  end

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Directed bench for mips_data_mem_arbiter: vector table plus burst, reset and tie sequences.
module tb_mips_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_address, cpu_writedata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readvalid;
  logic        dma_read, dma_write;
  logic [31:0] dma_address, dma_writedata;
  logic        dma_waitrequest;
  logic [31:0] dma_readdata;
  logic        dma_readvalid;
  logic [31:0] mem_address, mem_writedata;
  logic        mem_write, mem_read;
  logic [31:0] mem_readdata;
  logic        grant_dma;

  int n_checks = 0;
  int n_errors = 0;

  mips_data_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readvalid(cpu_readvalid),
    .dma_read(dma_read), .dma_write(dma_write),
    .dma_address(dma_address), .dma_writedata(dma_writedata),
    .dma_waitrequest(dma_waitrequest), .dma_readdata(dma_readdata),
    .dma_readvalid(dma_readvalid),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_readdata(mem_readdata), .grant_dma(grant_dma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple data memory: one-cycle read latency, frozen when clk_enable is low.
  logic [31:0] bmem [0:255];
  always @(posedge clk) begin
    if (!reset) begin
      bmem[8'h10] <= 32'hFFFF_FFFF;
      bmem[8'h30] <= 32'hA5A5_0030;
    end else if (clk_enable) begin
      if (mem_write) bmem[mem_address[7:0]] <= mem_writedata;
      if (mem_read) mem_readdata <= bmem[mem_address[7:0]];
    end
  end

  typedef struct packed {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da;
    logic        en;
    logic        e_mr, e_mw;
    logic [31:0] e_ma, e_mwd;
    logic        e_cwt, e_dwt, e_crv;
    logic [31:0] e_crd;
    logic        e_drv;
    logic [31:0] e_drd;
    logic        e_gd;
  } vec_t;

  vec_t vecs [0:14];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic dr, input logic dw, input logic [31:0] da, input logic en,
    input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] mwd,
    input logic cwt, input logic dwt, input logic crv, input logic [31:0] crd,
    input logic drv, input logic [31:0] drd, input logic gd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.en = en;
    v.e_mr = mr; v.e_mw = mw; v.e_ma = ma; v.e_mwd = mwd;
    v.e_cwt = cwt; v.e_dwt = dwt; v.e_crv = crv; v.e_crd = crd;
    v.e_drv = drv; v.e_drd = drd; v.e_gd = gd;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag,
    input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] mwd,
    input logic cwt, input logic dwt, input logic crv, input logic [31:0] crd,
    input logic drv, input logic [31:0] drd, input logic gd);
    check_bit ({tag, " mem_read"},        mem_read,        mr);
    check_bit ({tag, " mem_write"},       mem_write,       mw);
    check_word({tag, " mem_address"},     mem_address,     ma);
    check_word({tag, " mem_writedata"},   mem_writedata,   mwd);
    check_bit ({tag, " cpu_waitrequest"}, cpu_waitrequest, cwt);
    check_bit ({tag, " dma_waitrequest"}, dma_waitrequest, dwt);
    check_bit ({tag, " cpu_readvalid"},   cpu_readvalid,   crv);
    check_word({tag, " cpu_readdata"},    cpu_readdata,    crd);
    check_bit ({tag, " dma_readvalid"},   dma_readvalid,   drv);
    check_word({tag, " dma_readdata"},    dma_readdata,    drd);
    check_bit ({tag, " grant_dma"},       grant_dma,       gd);
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic en);
    cpu_read = cr; cpu_write = cw; cpu_address = ca; cpu_writedata = cd;
    dma_read = dr; dma_write = dw; dma_address = da; dma_writedata = dd;
    clk_enable = en;
  endtask

  initial begin
    //             cr    cw    ca            cd            dr    dw    da        en    mr    mw    ma        mwd           cwt   dwt   crv   crd           drv   drd           gd
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h10,      32'h0,       1'b1, 1'b0, 32'h30, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 1'b0, 32'h30, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0,       1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,      1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hA5A50030, 1'b1);
    vecs[4]  = mk(1'b1, 1'b1, 32'h20,      32'h12345678, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h20,      32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h20, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0,      1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 32'h10,      32'h0,       1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 32'h10,      32'h0,       1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[10] = mk(1'b1, 1'b0, 32'h10,      32'h0,       1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[11] = mk(1'b1, 1'b0, 32'h10,      32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h10, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,      1'b0);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,      1'b0);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0);

    // Reset state, including wait-request echoing a request while held in reset.
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #2;
    check_outs("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    #1;
    check_outs("reset_req", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // Table: tie after reset, plain reads, read+write, clock-enable freeze.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].dr, vecs[i].dw, vecs[i].da, 32'h0, vecs[i].en);
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_ma, vecs[i].e_mwd,
                 vecs[i].e_cwt, vecs[i].e_dwt, vecs[i].e_crv, vecs[i].e_crd,
                 vecs[i].e_drv, vecs[i].e_drd, vecs[i].e_gd);
    end

    // DMA write burst; CPU reads from cycle 1 and is let in after four DMA beats.
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      drive((c >= 1 && c <= 4), 1'b0, 32'h10, 32'h0,
            1'b0, (c < 6), 32'h80 + 32'(c), 32'(c), 1'b1);
      @(negedge clk);
      check_bit($sformatf("burst%0d dma_waitrequest", c), dma_waitrequest, (c == 4));
      check_bit($sformatf("burst%0d cpu_waitrequest", c), cpu_waitrequest, (c >= 1 && c <= 3));
      check_bit($sformatf("burst%0d mem_write", c), mem_write, (c < 6 && c != 4));
      check_bit($sformatf("burst%0d mem_read", c), mem_read, (c == 4));
      check_bit($sformatf("burst%0d grant_dma", c), grant_dma, ((c >= 1 && c <= 4) || c == 6));
      check_bit($sformatf("burst%0d cpu_readvalid", c), cpu_readvalid, (c == 5));
      if (c == 5) check_word("burst5 cpu_readdata", cpu_readdata, 32'hFFFF_FFFF);
    end

    // Reset pulled the cycle after a DMA read issue: the response must be dropped.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    @(negedge clk);
    check_outs("rst_issue", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outs("rst_release", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    @(negedge clk);
    check_outs("rst_tie", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    check_outs("rst_tie_resp", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_data_mem_arbiter.md
# mips_data_mem_arbiter

Two-master arbiter that shares the single `mips_cpu_data_memory` port between the `mips_cpu_harvard` data port and a DMA/test-loader port. It issues at most one memory transaction per cycle, stalls the losing requester with a wait-request, and routes each read response back to its issuer. Ownership is round-robin with bounded bursts, so neither master starves. The block sits between the CPU/loader and `mips_cpu_data_memory` in the Harvard top level.

## Interface
- `MAX_BURST`, 4, maximum consecutive beats the owner keeps while the other master waits (≥1)
- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low
- `clk_enable` in 1, global clock enable; all state frozen when 0
- `cpu_read`, `cpu_write` in 1 each, CPU request strobes
- `cpu_address` in 32, word address; `cpu_writedata` in 32
- `cpu_waitrequest` out 1, request present but not issued this cycle
- `cpu_readdata` out 32, `cpu_readvalid` out 1, read response
- `dma_read`, `dma_write`, `dma_address`, `dma_writedata`, `dma_waitrequest`, `dma_readdata`, `dma_readvalid`: same as the CPU set, for the DMA master
- `mem_address` out 32, `mem_writedata` out 32, `mem_write` out 1, `mem_read` out 1: to the memory
- `mem_readdata` in 32, valid the enabled cycle after `mem_read` is issued
- `grant_dma` out 1, 1 when the DMA master is the current owner (status)

## Operation
- Request per master: `req = read | write`. If read and write are both 1, write wins and the read is ignored.
- State: `owner` ∈ {NONE, CPU, DMA}; `beats` counter, 0..MAX_BURST; `rr_last` (last master served); response tag `{pend_valid, pend_who}`.
- The grant for the current cycle is computed combinationally:
  - If `owner` is requesting and (`beats` < MAX_BURST or the other master is idle): grant `owner`.
  - Otherwise, if the other master is requesting: grant the other master.
  - Otherwise, if `owner` is requesting: grant `owner`.
  - If `owner` = NONE and both masters request: grant the master ≠ `rr_last`.
  - If no master requests: no grant.
- Issue: the granted master's address, data and strobes drive `mem_*`. With no grant, `mem_read` = `mem_write` = 0 and `mem_address`/`mem_writedata` = 0.
- Waitrequest: `x_waitrequest` = `x_req` & !(granted x & `clk_enable`).
- On an enabled edge:
  - Granted same as `owner`: `beats` saturates at MAX_BURST.
  - Ownership changes: `owner` ← granted master, `beats` ← 1, `rr_last` ← granted master.
  - No grant: `owner` ← NONE, `beats` ← 0.
- Reads: an issued read sets `pend_valid` = 1 and `pend_who` = issuer. In the next enabled cycle, `mem_readdata` passes to `x_readdata` and `x_readvalid` = 1 for `pend_who`. The other master's readdata is 0.
- Writes complete in the issue cycle and produce no response.
- Pipelining: a new issue may occur in the same cycle a previous read's response returns. Back-to-back reads give one response per cycle.
- `grant_dma` = (`owner` == DMA).

## Timing
- Reset (`reset` = 0, asynchronous):
  - State: `owner` = NONE, `beats` = 0, `rr_last` = DMA (CPU wins the first tie), `pend_valid` = 0.
  - Outputs: `mem_read` = `mem_write` = 0, both readvalid = 0, both readdata = 0, `grant_dma` = 0.
  - Waitrequest = `x_req` for each master.
- Reset asserted mid-burst or with a read pending: the pending response is discarded and no readvalid is produced after release.
- Issue latency: 0 cycles for an uncontended request, since the grant is combinational and matches the CPU's in-cycle memory access.
- Read response: exactly 1 enabled cycle after issue.
- `clk_enable` = 0:
  - No issue: `mem_read`/`mem_write` = 0 and all requests wait.
  - Registers hold their values.
  - A response already visible stays visible until the next enabled edge.
- Fairness: a continuously requesting master waits at most MAX_BURST issued beats of the other master.
- `MAX_BURST` = 1 reduces to strict alternation under contention.

## Test plan
- Uncontended CPU read: `cpu_read` = 1, address 0x10, memory holds 0xFFFFFFFF.
  - Issue cycle: `mem_read` = 1, `cpu_waitrequest` = 0.
  - Next cycle: `cpu_readvalid` = 1, `cpu_readdata` = 0xFFFFFFFF.
  - `dma_readvalid` stays 0.
- Tie after reset: both masters request a read in the same cycle.
  - Cycle 0: CPU granted, `dma_waitrequest` = 1.
  - Cycle 1: DMA granted (CPU no longer requesting).
  - Each response is tagged to the correct master.
- Burst bound, MAX_BURST = 4: DMA writes continuously while the CPU requests from cycle 1.
  - DMA issues 4 beats (`grant_dma` = 1), then the CPU is granted on the 5th cycle.
  - DMA resumes afterwards.
- Read+write together: `cpu_read` = `cpu_write` = 1, data 0x12345678 to address 0x20.
  - Only `mem_write` is asserted.
  - A later read of 0x20 returns 0x12345678 and no readvalid follows the write.
- `clk_enable` deasserted for 3 cycles with the CPU requesting:
  - `mem_read` = 0 and `cpu_waitrequest` = 1 throughout.
  - Issue occurs on the first re-enabled cycle, with the response one cycle later.
- Reset pulled low the cycle after a DMA read issue:
  - `dma_readvalid` never asserts.
  - After release: `owner` = NONE, and the CPU wins the next tie.
